// File: rtl/ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ir_decoder
// Description : Pulse-distance IR frame receiver. Synchronizes and
//               deglitches the demodulated envelope, times every mark and
//               space with a saturating counter, and rebuilds a 32-bit word
//               sent LSB first behind a start mark/space pair. The word is
//               offered on a valid/ready handshake.
//
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               ir_in    - demodulated IR envelope, asynchronous to clk
//               cmd      - decoded command, stable while valid=1
//               valid    - cmd holds an unconsumed frame
//               ready    - consumer accepts cmd when valid&&ready
//               err      - one-cycle pulse on a protocol violation
//               overrun  - one-cycle pulse when a frame is dropped because
//                          the previous one was still pending
//
// Revision    : 1.0 - initial release
// ============================================================================
module ir_decoder #(
    parameter int START_TICKS  = 109250,
    parameter int BIT_TICKS    = 10416,
    parameter int GLITCH_TICKS = 16,
    parameter bit INVERT       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_in,
    output logic [31:0] cmd,
    output logic        valid,
    input  logic        ready,
    output logic        err,
    output logic        overrun
);

    // Acceptance windows (closed intervals) and the post-frame quiet time.
    localparam int          c_TS       = START_TICKS / 4;
    localparam int          c_TB       = BIT_TICKS / 4;
    localparam logic [23:0] c_START_LO = 24'(START_TICKS - c_TS);
    localparam logic [23:0] c_START_HI = 24'(START_TICKS + c_TS);
    localparam logic [23:0] c_BIT_LO   = 24'(BIT_TICKS - c_TB);
    localparam logic [23:0] c_BIT_HI   = 24'(BIT_TICKS + c_TB);
    localparam logic [23:0] c_ONE_LO   = 24'(3 * BIT_TICKS - c_TB);
    localparam logic [23:0] c_ONE_HI   = 24'(3 * BIT_TICKS + c_TB);

    localparam int                c_GW         = (GLITCH_TICKS > 1) ? $clog2(GLITCH_TICKS) : 1;
    localparam logic [c_GW-1:0]   c_GLITCH_MAX = c_GW'(GLITCH_TICKS - 1);

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_START_MARK  = 3'd1;
    localparam logic [2:0] c_ST_START_SPACE = 3'd2;
    localparam logic [2:0] c_ST_BIT_MARK    = 3'd3;
    localparam logic [2:0] c_ST_BIT_SPACE   = 3'd4;
    localparam logic [2:0] c_ST_QUIET       = 3'd5;

    logic [1:0]      r_sync;
    logic            r_mark;
    logic            r_mark_q;
    logic [c_GW-1:0] r_gcnt;
    logic [23:0]     r_cnt;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [4:0]      r_idx;
    logic [30:0]     r_shift;
    logic [31:0]     r_cmd;
    logic            r_valid;
    logic            r_err;
    logic            r_ovr;

    logic            w_level;
    logic            w_rise;
    logic            w_fall;
    logic            w_edge;
    logic            w_err;
    logic            w_done;
    logic            w_clr;
    logic            w_shift;
    logic            w_bit;

    // Synchronizer flops come out of reset at the idle (space) line level so
    // the filter never sees a phantom mark after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{INVERT}};
        end else begin
            r_sync <= {r_sync[0], ir_in};
        end
    end

    assign w_level = r_sync[1] ^ INVERT;

    // Glitch filter: the accepted level flips only after GLITCH_TICKS
    // consecutive samples disagree with it; any agreeing sample restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mark   <= 1'b0;
            r_mark_q <= 1'b0;
            r_gcnt   <= '0;
        end else begin
            r_mark_q <= r_mark;
            if (w_level != r_mark) begin
                if (r_gcnt == c_GLITCH_MAX) begin
                    r_mark <= w_level;
                    r_gcnt <= '0;
                end else begin
                    r_gcnt <= r_gcnt + 1'b1;
                end
            end else begin
                r_gcnt <= '0;
            end
        end
    end

    assign w_rise = r_mark & ~r_mark_q;
    assign w_fall = ~r_mark & r_mark_q;
    assign w_edge = r_mark ^ r_mark_q;

    // On an edge cycle r_cnt still holds the length of the level just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= 24'd1;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        w_bit       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rise) w_state_nxt = c_ST_START_MARK;
            end
            c_ST_START_MARK: begin
                if (w_fall) begin
                    if (r_cnt >= c_START_LO && r_cnt <= c_START_HI) w_state_nxt = c_ST_START_SPACE;
                    else                                            w_err = 1'b1;
                end else if (r_cnt > c_START_HI) begin
                    w_err = 1'b1;
                end
            end
            c_ST_START_SPACE: begin
                if (w_rise) begin
                    if (r_cnt >= c_START_LO && r_cnt <= c_START_HI) begin
                        w_clr       = 1'b1;
                        w_state_nxt = c_ST_BIT_MARK;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (r_cnt > c_START_HI) begin
                    w_err = 1'b1;
                end
            end
            c_ST_BIT_MARK: begin
                if (w_fall) begin
                    if (r_cnt >= c_BIT_LO && r_cnt <= c_BIT_HI) begin
                        // The last bit's space merges into the inter-frame
                        // gap, so the frame ends on its mark.
                        if (r_idx == 5'd31) begin
                            w_done      = 1'b1;
                            w_state_nxt = c_ST_QUIET;
                        end else begin
                            w_state_nxt = c_ST_BIT_SPACE;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (r_cnt > c_BIT_HI) begin
                    w_err = 1'b1;
                end
            end
            c_ST_BIT_SPACE: begin
                if (w_rise) begin
                    if (r_cnt >= c_BIT_LO && r_cnt <= c_BIT_HI) begin
                        w_shift     = 1'b1;
                        w_state_nxt = c_ST_BIT_MARK;
                    end else if (r_cnt >= c_ONE_LO && r_cnt <= c_ONE_HI) begin
                        w_shift     = 1'b1;
                        w_bit       = 1'b1;
                        w_state_nxt = c_ST_BIT_MARK;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (r_cnt > c_ONE_HI) begin
                    w_err = 1'b1;
                end
            end
            c_ST_QUIET: begin
                // Marks here only restart the timer; leave once the line has
                // been quiet long enough to rule out a trailing "1" space.
                if (!r_mark && r_cnt >= c_ONE_HI) w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_err) w_state_nxt = c_ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (w_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (w_shift) begin
            r_shift[r_idx] <= w_bit;
            r_idx          <= r_idx + 5'd1;
        end
    end

    // A completing frame may replace cmd only if the slot is free or is
    // being consumed on this very cycle; otherwise it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_err <= w_err;
            r_ovr <= w_done && r_valid && !ready;
            if (w_done && (!r_valid || ready)) begin
                r_cmd   <= {1'b0, r_shift};
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign valid   = r_valid;
    assign err     = r_err;
    assign overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_decoder
// Description : Self-checking bench for ir_decoder. Frames are described as
//               lists of mark/space durations; a reference model judges each
//               list against the timing windows and predicts either a word
//               or an error. Predicted words go to a scoreboard that a
//               monitor drains on every valid&&ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_decoder;

    localparam int P_START  = 96;
    localparam int P_BIT    = 24;
    localparam int P_GLITCH = 4;
    localparam int P_GAP    = 150;
    localparam int P_TS     = P_START / 4;
    localparam int P_TB     = P_BIT / 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_in = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] cmd;
    logic        valid;
    logic        err;
    logic        overrun;

    ir_decoder #(
        .START_TICKS (P_START),
        .BIT_TICKS   (P_BIT),
        .GLITCH_TICKS(P_GLITCH),
        .INVERT      (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ir_in  (ir_in),
        .cmd    (cmd),
        .valid  (valid),
        .ready  (ready),
        .err    (err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          err_seen = 0;
    int          ovr_seen = 0;
    int          exp_err  = 0;
    int          exp_ovr  = 0;
    logic [31:0] sb[$];
    int          dq[$];   // element 0 start mark, 1 start space, then bit mark/space pairs
    bit          gq[$];   // inject a short glitch in the middle of this element

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count pulses and drain the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err)     err_seen++;
            if (overrun) ovr_seen++;
            if (valid && ready) begin
                chk("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("cmd", cmd, sb.pop_front());
            end
        end
    end

    function automatic bit inwin(input int d, input int nom, input int tol);
        return (d >= nom - tol) && (d <= nom + tol);
    endfunction

    // Reference model: returns 1 if the duration list must end in an error.
    // The last bit has no measurable space, so bit 31 is never set.
    function automatic bit model(output logic [31:0] w);
        w = 32'h0;
        for (int i = 0; i < dq.size(); i++) begin
            if (i < 2) begin
                if (!inwin(dq[i], P_START, P_TS)) return 1'b1;
            end else if ((i - 2) % 2 == 0) begin
                if (!inwin(dq[i], P_BIT, P_TB)) return 1'b1;
            end else begin
                if (inwin(dq[i], 3 * P_BIT, P_TB))  w[(i - 2) / 2] = 1'b1;
                else if (!inwin(dq[i], P_BIT, P_TB)) return 1'b1;
            end
        end
        // A frame cut short leaves the decoder waiting on an overlong level.
        return dq.size() != 65;
    endfunction

    function automatic int jit(input bit en, input int amp);
        if (!en) return 0;
        return int'($urandom_range(2 * amp, 0)) - amp;
    endfunction

    task automatic build(input logic [31:0] w, input bit jen);
        dq.delete();
        gq.delete();
        dq.push_back(P_START + jit(jen, 20)); gq.push_back(1'b0);
        dq.push_back(P_START + jit(jen, 20)); gq.push_back(1'b0);
        for (int b = 0; b < 32; b++) begin
            dq.push_back(P_BIT + jit(jen, 5)); gq.push_back(1'b0);
            if (b < 31) begin
                dq.push_back((w[b] ? 3 * P_BIT : P_BIT) + jit(jen, 5));
                gq.push_back(1'b0);
            end
        end
    endtask

    task automatic trunc(input int n);
        while (dq.size() > n) begin
            void'(dq.pop_back());
            void'(gq.pop_back());
        end
    endtask

    task automatic drive_level(input bit lvl, input int n);
        ir_in = lvl ? 1'b0 : 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_elems();
        @(negedge clk);
        for (int i = 0; i < dq.size(); i++) begin
            bit lvl;
            lvl = (i % 2 == 0);
            if (gq[i]) begin
                drive_level(lvl, dq[i] / 2);
                drive_level(!lvl, 2);
                drive_level(lvl, dq[i] - dq[i] / 2 - 2);
            end else begin
                drive_level(lvl, dq[i]);
            end
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        ready = v;
    endtask

    // Predict, drive, then confirm pulse counts (and delivery if ready=1).
    task automatic run_frame(input bit dropped);
        logic [31:0] w;
        bit          e;
        e = model(w);
        if (e)            exp_err++;
        else if (dropped) exp_ovr++;
        else              sb.push_back(w);
        drive_elems();
        drive_level(1'b0, P_GAP);
        chk("err_count", 32'(err_seen), 32'(exp_err));
        chk("ovr_count", 32'(ovr_seen), 32'(exp_ovr));
        if (ready) chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a_exp;
        logic [31:0] x_exp;
        int          e;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", cmd, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_ovr", {31'h0, overrun}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_ready(1'b1);
        drive_level(1'b0, 20);

        // Nominal legal frame.
        build(32'h1234_5678, 1'b0);
        run_frame(1'b0);

        // Bit-mark tolerance edges on bit 5.
        build(32'h0F0F_0F0F, 1'b0); dq[12] = P_BIT + P_TB;     run_frame(1'b0);
        build(32'h0F0F_0F0F, 1'b0); dq[12] = P_BIT + P_TB + 1; trunc(13); run_frame(1'b0);
        build(32'h0F0F_0F0F, 1'b0); dq[12] = P_BIT - P_TB;     run_frame(1'b0);
        build(32'h0F0F_0F0F, 1'b0); dq[12] = P_BIT - P_TB - 1; trunc(13); run_frame(1'b0);

        // Short start mark, then recovery.
        build(32'h0000_0001, 1'b0); dq[0] = 70; trunc(1); run_frame(1'b0);
        build(32'h5A5A_A5A5, 1'b1); run_frame(1'b0);

        // Back-to-back frames with the consumer stalled.
        set_ready(1'b0);
        build(32'h00C0_FFEE, 1'b1);
        void'(model(a_exp));
        run_frame(1'b0);
        chk("ovr_valid_held", {31'h0, valid}, 32'h1);
        chk("ovr_cmd_first", cmd, a_exp);
        build(32'h7777_1111, 1'b1);
        run_frame(1'b1);
        chk("ovr_cmd_kept", cmd, a_exp);
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ovr_valid_fall", {31'h0, valid}, 32'h0);
        chk("ovr_sb_drained", 32'(sb.size()), 32'd0);

        // Sub-filter glitches in marks and spaces leave the word intact.
        build(32'h0000_FFFF, 1'b0);
        foreach (gq[i]) gq[i] = (i % 7 == 0) || (i == 1) || (i == 40);
        run_frame(1'b0);
        // A pulse long enough to pass the filter splits a "1" space.
        build(32'h0000_FFFF, 1'b0);
        dq[9] = 36; trunc(10); dq.push_back(8); gq.push_back(1'b0);
        run_frame(1'b0);

        // Randomized frames, some with one out-of-window element.
        for (int r = 0; r < 6; r++) begin
            build($urandom, 1'b1);
            case ($urandom_range(9, 0))
                6: begin e = 2 + 2 * int'($urandom_range(31, 0)); dq[e] = 31 + int'($urandom_range(9, 0)); trunc(e + 1); end
                7: begin e = 2 + 2 * int'($urandom_range(31, 0)); dq[e] = 5 + int'($urandom_range(12, 0)); trunc(e + 1); end
                8, 9: begin e = 3 + 2 * int'($urandom_range(30, 0)); dq[e] = 5 + int'($urandom_range(12, 0)); trunc(e + 2); end
                default: ;
            endcase
            run_frame(1'b0);
        end

        // Reset in the middle of bit 17 while an older frame is pending.
        set_ready(1'b0);
        build(32'h0BAD_F00D, 1'b1);
        void'(model(x_exp));
        drive_elems();
        drive_level(1'b0, P_GAP);
        chk("pre_rst_valid", {31'h0, valid}, 32'h1);
        chk("pre_rst_cmd", cmd, x_exp);
        build(32'h3141_5926, 1'b0);
        trunc(36);
        drive_elems();
        drive_level(1'b1, 10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, valid}, 32'h0);
        chk("mid_rst_cmd", cmd, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        chk("mid_rst_ovr", {31'h0, overrun}, 32'h0);
        repeat (3) @(posedge clk);
        ir_in = 1'b1;
        #2;
        rst_n = 1'b1;
        set_ready(1'b1);
        drive_level(1'b0, 20);
        build(32'h2718_2818, 1'b1);
        run_frame(1'b0);

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
